// File: rtl/rc4_decryption.sv
// RC4 stream decryptor.
//
// Builds the RC4 keystream from a KEY_BYTES-byte key and XORs it onto incoming
// ciphertext bytes to recover plaintext. The output register has valid/ready
// back-pressure, and a single-cycle rekey pulse abandons the current stream and
// starts again from state-array initialisation.
//
// Ports:
//   clock                 system clock, all logic on the rising edge
//   rst                   synchronous active-high reset
//   key                   key, byte n is key[8n+7:8n]
//   valid_key             key present, sampled only while ready_for_key=1
//   rekey                 single-cycle pulse, restart from INIT
//   ciphertext, valid_din input byte and its valid
//   ready_for_key         high only while waiting for a key
//   ready_for_ciphertext  input handshake ready (combinational)
//   plaintext, valid_dout registered output byte and its valid
//   ready_dout            downstream ready
module rc4_decryption #(
    parameter int KEY_BYTES = 16
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [KEY_BYTES*8-1:0] key,
    input  logic                   valid_key,
    input  logic                   rekey,
    input  logic [7:0]             ciphertext,
    input  logic                   valid_din,
    output logic                   ready_for_key,
    output logic                   ready_for_ciphertext,
    output logic [7:0]             plaintext,
    output logic                   valid_dout,
    input  logic                   ready_dout
);

    localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [1:0] {
        INIT,
        WAIT_KEY,
        KSA,
        STREAM
    } state_t;

    state_t         state;
    logic [7:0]     s [256];
    logic [7:0]     kb [KEY_BYTES];
    logic [7:0]     i;
    logic [7:0]     j;
    logic [8:0]     counter;

    logic [KIW-1:0] key_idx;
    logic [7:0]     ksa_jn;
    logic [7:0]     st_in;
    logic [7:0]     st_si;
    logic [7:0]     st_jn;
    logic [7:0]     st_sj;
    logic [7:0]     st_t;
    logic [7:0]     ks;
    logic           accept;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        key_idx = KIW'(int'(i) % KEY_BYTES);
        ksa_jn  = j + s[i] + kb[key_idx];

        st_in = i + 8'd1;
        st_si = s[st_in];
        st_jn = j + st_si;
        st_sj = s[st_jn];
        st_t  = st_si + st_sj;

        // The keystream byte is S[t] after the swap. The swap only moves the
        // two entries at in and jn, so those positions are patched; any other
        // position reads the unchanged array.
        if (st_t == st_in) begin
            ks = st_sj;
        end else if (st_t == st_jn) begin
            ks = st_si;
        end else begin
            ks = s[st_t];
        end

        // A new byte may enter whenever the output register is empty or is
        // being drained in this same cycle.
        ready_for_ciphertext = (state == STREAM) && (!valid_dout || ready_dout);
        accept               = valid_din && ready_for_ciphertext;
    end

    // NOTE: s and kb have no reset; INIT rewrites every S entry and the key is
    // always reloaded before it is used, so clearing them would only cost logic.
    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= INIT;
            counter       <= '0;
            i             <= '0;
            j             <= '0;
            valid_dout    <= 1'b0;
            plaintext     <= '0;
            ready_for_key <= 1'b0;
        end else if (rekey) begin
            // Rekey wins over a same-cycle accept and drops any pending byte.
            state         <= INIT;
            counter       <= '0;
            valid_dout    <= 1'b0;
            ready_for_key <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    s[counter[7:0]] <= counter[7:0];
                    counter         <= counter + 9'd1;
                    if (counter == 9'd255) begin
                        state         <= WAIT_KEY;
                        ready_for_key <= 1'b1;
                    end
                end

                WAIT_KEY: begin
                    if (valid_key) begin
                        for (int n = 0; n < KEY_BYTES; n++) begin
                            kb[n] <= key[8*n +: 8];
                        end
                        i             <= '0;
                        j             <= '0;
                        counter       <= '0;
                        state         <= KSA;
                        ready_for_key <= 1'b0;
                    end
                end

                KSA: begin
                    // NOTE: non-blocking writes make both sides of the swap read
                    // the pre-edge values; when i == ksa_jn the swap is a no-op.
                    s[i]      <= s[ksa_jn];
                    s[ksa_jn] <= s[i];
                    j         <= ksa_jn;
                    i         <= i + 8'd1;
                    if (i == 8'd255) begin
                        i     <= '0;
                        j     <= '0;
                        state <= STREAM;
                    end
                end

                STREAM: begin
                    if (accept) begin
                        s[st_in]   <= st_sj;
                        s[st_jn]   <= st_si;
                        plaintext  <= ciphertext ^ ks;
                        valid_dout <= 1'b1;
                        i          <= st_in;
                        j          <= st_jn;
                    end else if (ready_dout) begin
                        valid_dout <= 1'b0;
                    end
                end

                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_decryption.sv
// Self-checking bench for rc4_decryption.
//
// The stimulus side pushes the expected plaintext onto a scoreboard queue at
// the moment a ciphertext byte is accepted; a separate monitor pops and
// compares whenever an output byte is handed downstream. Expected plaintext is
// either a hand-written RFC 6229 keystream byte (ciphertext 00) or the original
// plaintext that a reference RC4 model encrypted.
module tb_rc4_decryption;

    localparam int KEY_BYTES = 16;
    localparam logic [127:0] RFC_KEY = 128'h100f0e0d0c0b0a090807060504030201;

    logic                   clock;
    logic                   rst;
    logic [KEY_BYTES*8-1:0] key;
    logic                   valid_key;
    logic                   rekey;
    logic [7:0]             ciphertext;
    logic                   valid_din;
    logic                   ready_for_key;
    logic                   ready_for_ciphertext;
    logic [7:0]             plaintext;
    logic                   valid_dout;
    logic                   ready_dout;

    logic rd_random;
    logic rd_rand_bit;
    logic rd_force;
    assign ready_dout = rd_random ? rd_rand_bit : rd_force;

    int n_cmp;
    int n_fail;
    logic [7:0] sb [$];

    // Reference RC4 state
    logic [7:0] ms [256];
    logic [7:0] mi;
    logic [7:0] mj;

    // RFC 6229, 128-bit key 01..10, keystream offset 0
    logic [7:0] rfc_ks [4] = '{8'h9a, 8'hc7, 8'hcc, 8'h9a};

    rc4_decryption #(.KEY_BYTES(KEY_BYTES)) dut (
        .clock                (clock),
        .rst                  (rst),
        .key                  (key),
        .valid_key            (valid_key),
        .rekey                (rekey),
        .ciphertext           (ciphertext),
        .valid_din            (valid_din),
        .ready_for_key        (ready_for_key),
        .ready_for_ciphertext (ready_for_ciphertext),
        .plaintext            (plaintext),
        .valid_dout           (valid_dout),
        .ready_dout           (ready_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always begin
        @(posedge clock);
        #1;
        rd_rand_bit = 1'($urandom_range(0, 1));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_init(input logic [127:0] k);
        logic [7:0] jj;
        logic [7:0] t;
        jj = 8'd0;
        for (int n = 0; n < 256; n++) ms[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            jj     = jj + ms[n] + k[8*(n % KEY_BYTES) +: 8];
            t      = ms[n];
            ms[n]  = ms[jj];
            ms[jj] = t;
        end
        mi = 8'd0;
        mj = 8'd0;
    endtask

    task automatic model_next(output logic [7:0] ksb);
        logic [7:0] t;
        mi     = mi + 8'd1;
        mj     = mj + ms[mi];
        t      = ms[mi];
        ms[mi] = ms[mj];
        ms[mj] = t;
        ksb    = ms[8'(ms[mi] + ms[mj])];
    endtask

    // Output monitor: one comparison per downstream handshake.
    always begin
        logic [7:0] exp_b;
        @(negedge clock);
        if (!rst && valid_dout && ready_dout) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got %02h, expected no byte", plaintext);
            end else begin
                exp_b = sb.pop_front();
                check("plaintext", {24'd0, plaintext}, {24'd0, exp_b});
            end
        end
    end

    // Offer one byte, hold it until accepted, push its expected plaintext.
    task automatic send_byte(input logic [7:0] ct, input logic [7:0] exp_b, output int waited);
        logic done;
        done       = 1'b0;
        waited     = 0;
        ciphertext = ct;
        valid_din  = 1'b1;
        while (!done) begin
            @(negedge clock);
            if (ready_for_ciphertext) begin
                sb.push_back(exp_b);
                done = 1'b1;
            end else if (waited >= 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: got no accept, expected accept within 200 cycles");
                done = 1'b1;
            end else begin
                waited++;
                tick();
            end
        end
        tick();
    endtask

    task automatic drain(input string name);
        int c;
        c         = 0;
        valid_din = 1'b0;
        while (sb.size() != 0 && c < 200) begin
            tick();
            c++;
        end
        check({name, "_drained"}, sb.size(), 0);
    endtask

    // Counts edges from the last rst/rekey edge until ready_for_key is seen.
    task automatic wait_key_ready(input int exp_cycles, input string name);
        int   c;
        logic seen;
        logic bad_valid;
        c         = 0;
        seen      = 1'b0;
        bad_valid = 1'b0;
        while (!seen && c < 400) begin
            @(negedge clock);
            if (valid_dout || ready_for_ciphertext) bad_valid = 1'b1;
            if (ready_for_key) seen = 1'b1;
            else begin
                c++;
                tick();
            end
        end
        check({name, "_key_ready_latency"}, c, exp_cycles);
        check({name, "_quiet_while_init"}, {31'd0, bad_valid}, 0);
        tick();
    endtask

    // Presents the key for 'hold' cycles; optionally measures the edges from the
    // sampling edge to the first ready_for_ciphertext (KSA is 256 cycles).
    task automatic load_key(input logic [127:0] k, input int hold, input logic measure, input string name);
        int   c;
        logic seen;
        logic bad_rfk;
        key       = k;
        valid_key = 1'b1;
        for (int h = 0; h < hold; h++) tick();
        valid_key = 1'b0;
        model_init(k);
        if (measure) begin
            c       = hold - 1;
            seen    = 1'b0;
            bad_rfk = 1'b0;
            while (!seen && c < 400) begin
                @(negedge clock);
                if (ready_for_key) bad_rfk = 1'b1;
                if (ready_for_ciphertext) seen = 1'b1;
                else begin
                    c++;
                    tick();
                end
            end
            check({name, "_stream_ready_latency"}, c, 256);
            check({name, "_key_ready_low_in_ksa"}, {31'd0, bad_rfk}, 0);
            tick();
        end
    endtask

    task automatic send_rfc_zeros(input string name);
        int         w;
        logic [7:0] ksb;
        for (int n = 0; n < 4; n++) begin
            model_next(ksb);
            send_byte(8'h00, rfc_ks[n], w);
            check({name, "_back_to_back"}, w, 0);
        end
        drain(name);
    endtask

    task automatic send_model_bytes(input int count, input logic check_b2b, input string name);
        int         w;
        logic [7:0] pt;
        logic [7:0] ksb;
        int         stalls;
        stalls = 0;
        for (int n = 0; n < count; n++) begin
            pt = 8'($urandom);
            model_next(ksb);
            send_byte(pt ^ ksb, pt, w);
            stalls += w;
        end
        if (check_b2b) check({name, "_back_to_back"}, stalls, 0);
    endtask

    initial begin
        logic [7:0] pt_a;
        logic [7:0] pt_b;
        logic [7:0] ksb;
        int         w;

        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        key        = '0;
        valid_key  = 1'b0;
        rekey      = 1'b0;
        ciphertext = 8'h00;
        valid_din  = 1'b0;
        rd_random  = 1'b0;
        rd_force   = 1'b1;

        // Reset state
        tick();
        @(negedge clock);
        check("rst_valid_dout", {31'd0, valid_dout}, 0);
        check("rst_plaintext", {24'd0, plaintext}, 0);
        check("rst_ready_for_key", {31'd0, ready_for_key}, 0);
        check("rst_ready_for_ciphertext", {31'd0, ready_for_ciphertext}, 0);
        tick();
        rst = 1'b0;
        wait_key_ready(256, "reset");

        // Key held two cycles: the second cycle must be ignored.
        load_key(RFC_KEY, 2, 1'b1, "key1");
        send_rfc_zeros("rfc");

        // 64 model-encrypted bytes back-to-back
        send_model_bytes(64, 1'b1, "b2b");
        drain("b2b");

        // 64 bytes with random downstream back-pressure
        rd_random = 1'b1;
        send_model_bytes(64, 1'b0, "bp");
        valid_din = 1'b0;
        rd_random = 1'b0;
        rd_force  = 1'b1;
        drain("bp");

        // Stall boundary: output held, input blocked for 10 cycles.
        rd_force = 1'b0;
        pt_a = 8'h5a;
        model_next(ksb);
        send_byte(pt_a ^ ksb, pt_a, w);
        pt_b = 8'hc3;
        model_next(ksb);
        ciphertext = pt_b ^ ksb;
        valid_din  = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            check("stall_valid_dout", {31'd0, valid_dout}, 1);
            check("stall_plaintext", {24'd0, plaintext}, {24'd0, pt_a});
            check("stall_ready_for_ciphertext", {31'd0, ready_for_ciphertext}, 0);
            tick();
        end
        rd_force = 1'b1;
        @(negedge clock);
        check("stall_release_accept", {31'd0, ready_for_ciphertext}, 1);
        if (ready_for_ciphertext) sb.push_back(pt_b);
        tick();
        drain("stall");

        // Mid-stream rekey after 5 bytes, with a byte offered in the rekey cycle.
        send_model_bytes(5, 1'b1, "pre_rekey");
        drain("pre_rekey");
        ciphertext = 8'h77;
        valid_din  = 1'b1;
        rekey      = 1'b1;
        tick();
        rekey     = 1'b0;
        valid_din = 1'b0;
        wait_key_ready(256, "rekey");
        load_key(RFC_KEY, 1, 1'b1, "key2");
        send_rfc_zeros("after_rekey");

        // Synchronous reset in the middle of KSA.
        rekey = 1'b1;
        tick();
        rekey = 1'b0;
        wait_key_ready(256, "rekey2");
        load_key(RFC_KEY, 1, 1'b0, "key3");
        for (int n = 0; n < 100; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_key_ready(256, "rst_mid_ksa");
        load_key(RFC_KEY, 1, 1'b1, "key4");
        send_rfc_zeros("after_rst");

        for (int n = 0; n < 3; n++) tick();
        check("final_scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_decryption.md
Name: rc4_decryption

Overview:
- Receive-side counterpart of the RC4 encryption block: rebuilds the RC4 keystream from the same 128-bit key and XORs it onto incoming ciphertext bytes to recover plaintext.
- Sits at the far end of the encrypted byte link.
- Adds output back-pressure and an in-band rekey, so it can feed a downstream consumer that may stall.

Parameters:
- KEY_BYTES, 16, key length in bytes. The key port is KEY_BYTES*8 bits wide, and the KSA key index wraps modulo KEY_BYTES.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key  in  KEY_BYTES*8  key; byte K[n] = key[8n+7:8n], K[0] is the first key byte.
- valid_key  in  1  key present; sampled only while ready_for_key=1.
- rekey  in  1  single-cycle pulse; abandons the current stream and restarts from INIT.
- ciphertext  in  8  ciphertext byte.
- valid_din  in  1  ciphertext byte valid.
- ready_for_key  out  1  high only in WAIT_KEY.
- ready_for_ciphertext  out  1  input handshake ready.
- plaintext  out  8  decrypted byte (registered).
- valid_dout  out  1  plaintext valid.
- ready_dout  in  1  downstream ready.

Behaviour:
- Storage and counters
  - State array S[0..255] of 8-bit registers.
  - 8-bit indices i and j; 9-bit loop counter. All index arithmetic is mod 256.
- Reset (rst=1 at a clock edge)
  - state<=INIT, counter<=0, i<=0, j<=0.
  - valid_dout<=0, plaintext<=0, ready_for_key=0, ready_for_ciphertext=0.
  - Applies in every state, mid-KSA and mid-stream included; any pending output byte is dropped.
- INIT (256 cycles)
  - S[c]<=c for c=0..255, one entry per cycle.
  - On c=255, go to WAIT_KEY.
- WAIT_KEY
  - ready_for_key=1.
  - On valid_key=1: latch key, clear i, j and counter, go to KSA.
  - If valid_key is held longer, it is ignored after the first cycle.
- KSA (256 cycles, one iteration per cycle)
  - jn = j + S[i] + K[i mod KEY_BYTES]; swap S[i] and S[jn]; j<=jn; i<=i+1.
  - i==jn is legal; the swap is then a no-op.
  - After i=255, clear i and j and go to STREAM.
- STREAM
  - ready_for_ciphertext = !valid_dout | ready_dout. This is combinational, so the block sustains 1 byte/cycle with ready_dout held high.
  - Accept when valid_din & ready_for_ciphertext:
    - in = i+1; Si = S[in]; jn = j+Si; Sj = S[jn].
    - Swap S[in] and S[jn]; t = Si+Sj.
    - ks = Sj if t==in; Si if t==jn (and t!=in); else S[t] (pre-swap value).
    - plaintext <= ciphertext ^ ks; valid_dout<=1; i<=in; j<=jn.
  - Latency: plaintext is valid the cycle after acceptance.
  - If valid_dout & ready_dout and no accept: valid_dout<=0.
  - Simultaneous drain and accept: the output register is overwritten and valid_dout stays 1, with no bubble.
  - valid_dout & !ready_dout: plaintext and valid_dout hold stable; ready_for_ciphertext=0; no keystream advance.
  - valid_din with ready_for_ciphertext=0 is not consumed; the source must hold the byte.
- rekey (in STREAM, WAIT_KEY or KSA)
  - Next state is INIT; valid_dout<=0 and the pending byte is discarded.
  - rekey takes priority over a same-cycle accept; that byte is not consumed.
  - rekey during INIT restarts the INIT count.
- ready_for_ciphertext=0 outside STREAM.
- Key-to-first-ready latency: valid_key sampled in cycle N puts ready_for_ciphertext high from cycle N+257.

Test Plan:
- Reset, then idle → ready_for_key rises exactly 256 cycles after rst deasserts; valid_dout stays 0 throughout.
- key bytes K[0..15]=01,02,…,10 (RFC 6229), 4 ciphertext bytes 00 with ready_dout=1 → plaintext 9a,c7,cc,9a on 4 consecutive cycles.
- Same key; encrypt 64 random bytes with a software RC4 model and feed them back-to-back → output equals the original plaintext byte-for-byte.
- Back-pressure: ready_dout toggled randomly (50%) over 64 bytes → no byte lost, duplicated or changed while stalled; the stream matches the model.
- Stall boundary: valid_dout=1, ready_dout=0 for 10 cycles with valid_din=1 → plaintext frozen, ready_for_ciphertext=0 for 10 cycles; the first accept occurs in the cycle ready_dout rises.
- Mid-stream rekey pulse after 5 bytes, then reload the same key → ready_for_key rises after 256 cycles; the first decrypted byte uses keystream byte 9a again. A second run with rst asserted mid-KSA gives the same result.
